delta_block_sequencer: RTL and testbench

- Stream front-end and sequencer for the 9-wide successive-difference (delta) datapath.
- Collects a byte stream into 9-sample blocks and presents each block in parallel to the datapath.
- Waits out the datapath latency, captures the 9 results, and re-serialises them downstream with valid/ready handshakes.
- Short final blocks are padded internally; only the real samples are emitted.

---
 rtl/delta_block_sequencer.sv | 141 ++++++++++++++
 tb/tb_delta_block_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_block_sequencer.sv
// delta_block_sequencer
// Collects a sample stream into 9-sample blocks and presents each block in
// parallel to the delta datapath. It then waits out the datapath latency,
// captures the nine results, and replays them downstream one beat at a time.
// Short blocks are padded with their last sample, so the padded deltas come
// out as zero. Only the real samples are emitted.
module delta_block_sequencer #(
  parameter int DATA_W     = 8,
  parameter int DP_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [9*DATA_W-1:0] dp_in,
  input  logic [9*DATA_W-1:0] dp_out,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_first,
  output logic                m_last,
  output logic                busy,
  output logic [CNT_W-1:0]    block_count
);

  localparam int             WCW       = (DP_LATENCY < 1) ? 1 : $clog2(DP_LATENCY + 1);
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(DP_LATENCY);
  localparam logic [3:0]     LAST_SLOT = 4'd8;

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] samples [9];
  logic [DATA_W-1:0] results [9];
  logic [3:0]        k;
  logic [3:0]        n;
  logic [3:0]        idx;
  logic [WCW-1:0]    wait_cnt;

  // The datapath sees the sample buffer directly, so dp_in stays stable for as long as the buffer is untouched.
  always_comb begin
    dp_in = '0;
    for (int j = 0; j < 9; j++) begin
      dp_in[j*DATA_W +: DATA_W] = samples[j];
    end
  end

  // Sequencer FSM: fill, wait for the datapath, then drain results with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FILL;
      k           <= '0;
      n           <= '0;
      idx         <= '0;
      wait_cnt    <= '0;
      s_ready     <= 1'b1;
      m_valid     <= 1'b0;
      m_first     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      busy        <= 1'b0;
      block_count <= '0;
      for (int j = 0; j < 9; j++) begin
        samples[j] <= '0;
        results[j] <= '0;
      end
    end else begin
      case (state)
        S_FILL: begin
          if (s_valid) begin
            for (int j = 0; j < 9; j++) begin
              if ((4'(j) == k) || (s_last && (4'(j) > k))) begin
                samples[j] <= s_data;
              end
            end
            if ((k == LAST_SLOT) || s_last) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
              n        <= k + 4'd1;
              s_ready  <= 1'b0;
              busy     <= 1'b1;
            end else begin
              k <= k + 4'd1;
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            for (int j = 0; j < 9; j++) begin
              results[j] <= dp_out[j*DATA_W +: DATA_W];
            end
            idx     <= '0;
            state   <= S_DRAIN;
            m_valid <= 1'b1;
            m_data  <= dp_out[DATA_W-1:0];
            m_first <= 1'b1;
            m_last  <= (n == 4'd1);
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_DRAIN: begin
          if (m_ready) begin
            if (idx == n - 4'd1) begin
              state       <= S_FILL;
              k           <= '0;
              block_count <= block_count + 1'b1;
              s_ready     <= 1'b1;
              busy        <= 1'b0;
              m_valid     <= 1'b0;
              m_first     <= 1'b0;
              m_last      <= 1'b0;
            end else begin
              idx     <= idx + 4'd1;
              m_data  <= results[idx + 4'd1];
              m_first <= 1'b0;
              m_last  <= ((idx + 4'd1) == (n - 4'd1));
            end
          end
        end

        default: begin
          state   <= S_FILL;
          s_ready <= 1'b1;
          busy    <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delta_block_sequencer.sv
// tb_delta_block_sequencer
// Drives sample blocks into the sequencer. A behavioural one-cycle delta
// datapath sits behind it. Expected beats go into a scoreboard queue as each
// sample is sent, and are compared against the beats the DUT hands downstream.
module tb_delta_block_sequencer;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            s_ready;
  logic [9*DW-1:0] dp_in;
  logic [9*DW-1:0] dp_out = '0;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic            m_first;
  logic            m_last;
  logic            busy;
  logic [15:0]     block_count;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      got_q[$];
  logic [7:0] blk[9];
  int         blk_len;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         accept_cyc = 0;
  int         first_valid_cyc = -1;

  delta_block_sequencer #(.DATA_W(DW), .DP_LATENCY(1), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .dp_in(dp_in),
    .dp_out(dp_out),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_first(m_first),
    .m_last(m_last),
    .busy(busy),
    .block_count(block_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count rising edges so that latencies can be measured.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath with one edge of latency: slot 0 passes through, and other slots take the successive difference.
  always @(posedge clk) begin
    for (int j = 0; j < 9; j++) begin
      if (j == 0) dp_out[7:0] <= dp_in[7:0];
      else        dp_out[j*8 +: 8] <= dp_in[j*8 +: 8] - dp_in[(j-1)*8 +: 8];
    end
  end

  task automatic set_block(input int len, input int v0, input int v1, input int v2,
                           input int v3, input int v4, input int v5, input int v6,
                           input int v7, input int v8);
    blk[0] = 8'(v0); blk[1] = 8'(v1); blk[2] = 8'(v2);
    blk[3] = 8'(v3); blk[4] = 8'(v4); blk[5] = 8'(v5);
    blk[6] = 8'(v6); blk[7] = 8'(v7); blk[8] = 8'(v8);
    blk_len = len;
  endtask

  // Send the current block. Push one expected beat per real sample as it is driven.
  task automatic applyStimulus();
    int         guard;
    beat_t      e;
    logic [7:0] prev;
    prev = 8'd0;
    for (int i = 0; i < blk_len; i++) begin
      s_data  = blk[i];
      s_valid = 1'b1;
      s_last  = (i == blk_len - 1);
      e.data  = (i == 0) ? blk[i] : 8'(blk[i] - prev);
      e.first = (i == 0);
      e.last  = (i == blk_len - 1);
      exp_q.push_back(e);
      prev = blk[i];
      guard = 0;
      while (!s_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL send_timeout sample=%0d s_ready=%0b required=1", i, s_ready);
      end
      @(negedge clk);
      accept_cyc = cyc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Record downstream beats with m_ready held high until nbeats have been seen.
  task automatic collect(input int nbeats);
    int guard;
    guard = 0;
    first_valid_cyc = -1;
    m_ready = 1'b1;
    while (got_q.size() < nbeats && guard < 300) begin
      if (m_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        got_q.push_back({m_data, m_first, m_last});
      end
      @(negedge clk);
      guard++;
    end
    if (got_q.size() < nbeats) begin
      checks++;
      failures++;
      $display("[TB] FAIL collect_timeout beats=%0d required=%0d", got_q.size(), nbeats);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, m_valid, m_first, m_last, busy} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b required=10000", {s_ready, m_valid, m_first, m_last, busy});
    end
    checks++;
    if (block_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_count got=%0d required=0", block_count);
    end
    checks++;
    if (dp_in !== '0 || m_data !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_data dp_in=%h m_data=%0d required=0", dp_in, m_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_block();
    beat_t e, g;
    set_block(9, 10, 12, 15, 15, 20, 18, 30, 31, 40);
    applyStimulus();
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_wait_flags busy=%0b s_ready=%0b required busy=1 s_ready=0", busy, s_ready);
    end
    collect(9);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("[TB] FAIL full_beat got d=%0d f=%0b l=%0b required d=%0d f=%0b l=%0b",
                 g.data, g.first, g.last, e.data, e.first, e.last);
      end
    end
    checks++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL full_beat_count left_exp=%0d left_got=%0d required 0", exp_q.size(), got_q.size());
    end
    checks++;
    if (first_valid_cyc - accept_cyc != 2) begin
      failures++;
      $display("[TB] FAIL full_latency got=%0d required=2", first_valid_cyc - accept_cyc);
    end
    checks++;
    if (block_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL full_count got=%0d required=1", block_count);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_short_block();
    beat_t e, g;
    set_block(3, 5, 7, 4, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    for (int j = 3; j < 9; j++) begin
      checks++;
      if (dp_in[j*8 +: 8] !== 8'd4) begin
        failures++;
        $display("[TB] FAIL short_pad slot=%0d got=%0d required=4", j, dp_in[j*8 +: 8]);
      end
    end
    collect(3);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_after_last s_ready=%0b m_valid=%0b required s_ready=1 m_valid=0", s_ready, m_valid);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("[TB] FAIL short_beat got d=%0d f=%0b l=%0b required d=%0d f=%0b l=%0b",
                 g.data, g.first, g.last, e.data, e.first, e.last);
      end
    end
    checks++;
    if (exp_q.size() != 0 || got_q.size() != 0 || block_count !== 16'd2) begin
      failures++;
      $display("[TB] FAIL short_count left_exp=%0d left_got=%0d count=%0d required 0 0 2",
               exp_q.size(), got_q.size(), block_count);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_wrap();
    beat_t e, g;
    set_block(9, 255, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    collect(9);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("[TB] FAIL wrap_beat got d=%0d f=%0b l=%0b required d=%0d f=%0b l=%0b",
                 g.data, g.first, g.last, e.data, e.first, e.last);
      end
    end
    checks++;
    if (exp_q.size() != 0 || got_q.size() != 0 || block_count !== 16'd3) begin
      failures++;
      $display("[TB] FAIL wrap_count left_exp=%0d left_got=%0d count=%0d required 0 0 3",
               exp_q.size(), got_q.size(), block_count);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t e, g, held;
    int    pat[4];
    int    p, guard;
    logic  was_valid;
    pat = '{1, 0, 0, 1};
    set_block(9, 1, 3, 6, 10, 15, 21, 28, 36, 45);
    applyStimulus();
    guard = 0;
    while (!m_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    p = 0;
    guard = 0;
    while (got_q.size() < 9 && guard < 300) begin
      m_ready = (pat[p] != 0);
      p = (p + 1) % 4;
      held = {m_data, m_first, m_last};
      was_valid = m_valid;
      if (m_valid && m_ready) got_q.push_back(held);
      if (m_valid) begin
        checks++;
        if (s_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL bp_s_ready got=%0b required=0", s_ready);
        end
      end
      @(negedge clk);
      guard++;
      if (was_valid && !m_ready) begin
        checks++;
        if (m_valid !== 1'b1 || {m_data, m_first, m_last} !== held) begin
          failures++;
          $display("[TB] FAIL bp_hold got v=%0b d=%0d required v=1 d=%0d", m_valid, m_data, held.data);
        end
      end
    end
    m_ready = 1'b1;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("[TB] FAIL bp_beat got d=%0d f=%0b l=%0b required d=%0d f=%0b l=%0b",
                 g.data, g.first, g.last, e.data, e.first, e.last);
      end
    end
    checks++;
    if (exp_q.size() != 0 || got_q.size() != 0 || block_count !== 16'd4 || s_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_end left_exp=%0d left_got=%0d count=%0d s_ready=%0b required 0 0 4 1",
               exp_q.size(), got_q.size(), block_count, s_ready);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    beat_t e, g;
    set_block(9, 3, 9, 27, 81, 243, 217, 139, 161, 227);
    applyStimulus();
    collect(4);
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || block_count !== 16'd0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_state m_valid=%0b count=%0d busy=%0b s_ready=%0b required 0 0 0 1",
               m_valid, block_count, busy, s_ready);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("[TB] FAIL midreset_beat got d=%0d required d=%0d", g.data, e.data);
      end
    end
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_block(9, 200, 100, 50, 25, 12, 6, 3, 1, 0);
    applyStimulus();
    collect(9);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("[TB] FAIL postreset_beat got d=%0d f=%0b l=%0b required d=%0d f=%0b l=%0b",
                 g.data, g.first, g.last, e.data, e.first, e.last);
      end
    end
    checks++;
    if (exp_q.size() != 0 || got_q.size() != 0 || block_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL postreset_count left_exp=%0d left_got=%0d count=%0d required 0 0 1",
               exp_q.size(), got_q.size(), block_count);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t e, g;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_block(1, 77, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    collect(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'd77, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL single_beat got=%0d beats d=%0d required 1 beat d=77 f=1 l=1",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 8'd0);
    end
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_extra m_valid=%0b s_ready=%0b required 0 1", m_valid, s_ready);
    end
    exp_q.delete();
    got_q.delete();
    set_block(9, 8, 16, 24, 32, 40, 48, 56, 64, 72);
    applyStimulus();
    collect(9);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("[TB] FAIL b2b_beat got d=%0d f=%0b l=%0b required d=%0d f=%0b l=%0b",
                 g.data, g.first, g.last, e.data, e.first, e.last);
      end
    end
    checks++;
    if (exp_q.size() != 0 || got_q.size() != 0 || block_count !== 16'd2) begin
      failures++;
      $display("[TB] FAIL b2b_count left_exp=%0d left_got=%0d count=%0d required 0 0 2",
               exp_q.size(), got_q.size(), block_count);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // Run every scenario in order, then report the totals.
  initial begin
    test_reset();
    test_full_block();
    test_short_block();
    test_wrap();
    test_backpressure();
    test_reset_mid_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
